// File: rtl/pipe_mul_seq.sv
// Iterative shift-add multiplier for the EX stage: one multiplier bit per cycle,
// early exit once the remaining multiplier bits are zero, pipeline stall while busy.
module pipe_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  acc;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic [WIDTH-1:0]  acc_step;
    logic [WIDTH-1:0]  mplier_step;
    logic [CNT_W-1:0]  cnt_step;
    logic              finish;

    assign accept      = (state != RUN) && start && !flush;
    assign acc_step    = mplier[0] ? (acc + mcand) : acc;
    assign mplier_step = mplier >> 1;
    assign cnt_step    = cnt - CNT_W'(1);
    // Stop early once no set multiplier bits remain; the counter bounds the worst case.
    assign finish      = (mplier_step == '0) || (cnt_step == '0);

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    // Stall drops in the done cycle so the instruction leaves EX with its product.
    assign stall = !flush && ((state == RUN) || start);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            RUN: begin
                if (flush)
                    state_nxt = IDLE;
                else if (finish)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= CNT_W'(WIDTH);
            end else if ((state == RUN) && !flush) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier_step;
                cnt    <= cnt_step;
                if (finish)
                    product <= acc_step;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mul_seq.sv
// Directed bench for pipe_mul_seq: stimulus pushes expected products into a queue,
// a monitor pops and compares on every done pulse; timing of stall/busy is checked inline.
module tb_pipe_mul_seq;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clock;
    logic             reset;
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] product;

    int n_cmp;
    int n_err;
    logic [WIDTH-1:0] exp_q[$];

    pipe_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .product(product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding multiply.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                check("product", 64'(product), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    // Full multiply with exact cycle checks: accept at t, RUN t+1..t+n, done at t+n+1.
    task automatic run_mul(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic [WIDTH-1:0] pv, input int n);
        a = av;
        b = bv;
        start = 1'b1;
        exp_q.push_back(pv);
        smp();
        check("stall_accept", 64'(stall), 64'd1);
        step();
        start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            smp();
            check("busy_run", 64'(busy), 64'd1);
            check("stall_run", 64'(stall), 64'd1);
            check("done_run", 64'(done), 64'd0);
            step();
        end
        smp();
        check("done_pulse", 64'(done), 64'd1);
        check("stall_done", 64'(stall), 64'd0);
        check("busy_done", 64'(busy), 64'd0);
        step();
        smp();
        check("done_gone", 64'(done), 64'd0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        smp();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        step();
        reset = 1'b0;

        // 1) 7*6: three RUN cycles
        run_mul(32'd7, 32'd6, 32'd42, 3);
        check("hold_42", 64'(product), 64'd42);
        // 2) 0xFFFF*0x10001: msb 16 -> 17 RUN cycles
        run_mul(32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 17);
        // 3) all-ones squared: full 32 iterations, low word 1
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
        // 4) b=0: single RUN cycle, then back-to-back accept in DONE
        a = 32'h1234;
        b = 32'h0;
        start = 1'b1;
        exp_q.push_back(32'h0);
        step();
        start = 1'b0;
        smp();
        check("b0_busy", 64'(busy), 64'd1);
        step();
        a = 32'd5;
        b = 32'd3;
        start = 1'b1;
        exp_q.push_back(32'd15);
        smp();
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_stall", 64'(stall), 64'd1);
        check("b2b_product0", 64'(product), 64'd0);
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            smp();
            check("b2b_busy", 64'(busy), 64'd1);
            check("b2b_stall_run", 64'(stall), 64'd1);
            step();
        end
        smp();
        check("b2b_done2", 64'(done), 64'd1);
        step();
        step();
        // 5) long multiply flushed mid-run; product keeps the old value
        a = 32'd3;
        b = 32'h80000000;
        start = 1'b1;
        exp_q.push_back(32'h80000000);
        step();
        start = 1'b0;
        for (int i = 1; i < 5; i++) step();
        flush = 1'b1;
        void'(exp_q.pop_back());
        smp();
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_busy", 64'(busy), 64'd1);
        step();
        flush = 1'b0;
        smp();
        check("postflush_busy", 64'(busy), 64'd0);
        check("postflush_done", 64'(done), 64'd0);
        check("postflush_product", 64'(product), 64'd15);
        step();
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        smp();
        check("sf_stall", 64'(stall), 64'd0);
        step();
        start = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("sf_busy", 64'(busy), 64'd0);
            check("sf_done", 64'(done), 64'd0);
            step();
        end
        // 6) reset mid-run aborts, then a fresh multiply completes
        a = 32'd9;
        b = 32'hFF;
        start = 1'b1;
        exp_q.push_back(32'd2295);
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        void'(exp_q.pop_back());
        step();
        smp();
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_stall", 64'(stall), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_product", 64'(product), 64'd0);
        step();
        reset = 1'b0;
        run_mul(32'd11, 32'd13, 32'd143, 4);
        check("final_product", 64'(product), 64'd143);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
